axi_bar_regfile_slave: RTL and testbench

//  AXI4 responder on the PCIe bridge master port (m_axi_pcie), clocked by axi_clk_pcie.

---
 rtl/axi_bar_regfile_slave.sv | 147 ++++++++++++++
 tb/tb_axi_bar_regfile_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_bar_regfile_slave.sv
// axi_bar_regfile_slave: AXI4 BAR register-file responder with byte strobes and INCR/FIXED bursts.
// Word 0 is a read-only ID; contents survive reset; read and write channels run independently.
module axi_bar_regfile_slave #(
   parameter int                DATA_W    = 128,
   parameter int                DEPTH     = 64,
   parameter int                BAR_BYTES = 65536,
   parameter logic [DATA_W-1:0] ID_VALUE  = 128'hAC0E_0002
) (
   input  logic                axi_clk_pcie,
   input  logic                sys_reset,
   input  logic [31:0]         awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic [2:0]          awprot,
   input  logic                awlock,
   input  logic [3:0]          awcache,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [31:0]         araddr,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   input  logic [2:0]          arprot,
   input  logic                arlock,
   input  logic [3:0]          arcache,
   input  logic                arvalid,
   output logic                arready,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready
);
   localparam int BYTES    = DATA_W / 8;
   localparam int ADDR_LSB = $clog2(BYTES);
   localparam int IDX_W    = $clog2(DEPTH);
   localparam int OFF_W    = $clog2(BAR_BYTES);
   localparam logic [OFF_W:0] SPAN = (OFF_W + 1)'(DEPTH * BYTES);
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
   typedef enum logic {R_IDLE, R_DATA} rst_t;
   logic [DATA_W-1:0] r_mem [DEPTH];
   wst_t              r_wstate, w_wstate_n;
   rst_t              r_rstate, w_rstate_n;
   logic [OFF_W-1:0]  r_waddr, r_raddr, w_roff;
   logic [7:0]        r_wlen, r_wcnt, r_rlen, r_rcnt, w_rlen, w_rcnt_n;
   logic [1:0]        r_wburst, r_rburst;
   logic              r_werr, r_rerr, w_rerr_n;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_rresp;
   logic              r_rlast;
   logic              w_ahs, w_whs, w_wlast, w_wrange, w_we, w_rload, w_rrange, w_ridle;
   logic [IDX_W-1:0]  w_widx, w_ridx;
   logic              w_unused;
   assign w_unused = ^{awprot, awlock, awcache, arprot, arlock, arcache, awaddr[31:OFF_W], araddr[31:OFF_W]};
   // Write channel
   always_ff @(posedge axi_clk_pcie)
      if (sys_reset) r_wstate <= W_IDLE;
      else r_wstate <= w_wstate_n;
   always_comb begin
      w_wstate_n = r_wstate;
      case (r_wstate)
         W_IDLE:  w_wstate_n = awvalid ? W_DATA : W_IDLE;
         W_DATA:  w_wstate_n = (wvalid && w_wlast) ? W_RESP : W_DATA;
         default: w_wstate_n = bready ? W_IDLE : W_RESP;
      endcase
   end
   always_comb begin
      awready = r_wstate == W_IDLE;
      wready  = r_wstate == W_DATA;
      bvalid  = r_wstate == W_RESP;
      bresp   = (r_wstate == W_RESP && r_werr) ? 2'b10 : 2'b00;
      arready = r_rstate == R_IDLE;
      rvalid  = r_rstate == R_DATA;
   end
   assign w_ahs    = awvalid && r_wstate == W_IDLE;
   assign w_whs    = wvalid && r_wstate == W_DATA;
   assign w_wlast  = wlast || r_wcnt == r_wlen;
   assign w_wrange = {1'b0, r_waddr} < SPAN;
   assign w_widx   = r_waddr[ADDR_LSB +: IDX_W];
   assign w_we     = w_whs && !sys_reset && !r_werr && w_wrange && w_widx != '0;
   always_ff @(posedge axi_clk_pcie)
      if (sys_reset) begin
         r_werr <= 1'b0;
         r_wcnt <= '0;
      end else if (w_ahs) begin
         r_waddr  <= awaddr[OFF_W-1:0];
         r_wlen   <= awlen;
         r_wburst <= awburst;
         r_wcnt   <= '0;
         r_werr   <= awsize != 3'(ADDR_LSB) || awburst[1];
      end else if (w_whs) begin
         r_wcnt  <= r_wcnt + 8'd1;
         r_waddr <= r_wburst == 2'b01 ? r_waddr + OFF_W'(BYTES) : r_waddr;
         r_werr  <= r_werr || !w_wrange || (wlast != (r_wcnt == r_wlen));
      end
   always_ff @(posedge axi_clk_pcie)
      if (w_we)
         for (int k = 0; k < BYTES; k++)
            if (wstrb[k]) r_mem[w_widx][k*8 +: 8] <= wdata[k*8 +: 8];
   // Read channel: each beat is looked up one cycle ahead and registered
   always_ff @(posedge axi_clk_pcie)
      if (sys_reset) r_rstate <= R_IDLE;
      else r_rstate <= w_rstate_n;
   always_comb begin
      w_rstate_n = r_rstate;
      case (r_rstate)
         R_IDLE:  w_rstate_n = arvalid ? R_DATA : R_IDLE;
         default: w_rstate_n = (rready && r_rlast) ? R_IDLE : R_DATA;
      endcase
   end
   assign w_ridle  = r_rstate == R_IDLE;
   assign w_rload  = w_ridle ? arvalid : rready && !r_rlast;
   assign w_roff   = w_ridle ? araddr[OFF_W-1:0] : (r_rburst == 2'b01 ? r_raddr + OFF_W'(BYTES) : r_raddr);
   assign w_rerr_n = w_ridle ? (arsize != 3'(ADDR_LSB) || arburst[1]) : r_rerr;
   assign w_rcnt_n = w_ridle ? 8'd0 : r_rcnt + 8'd1;
   assign w_rlen   = w_ridle ? arlen : r_rlen;
   assign w_rrange = {1'b0, w_roff} < SPAN;
   assign w_ridx   = w_roff[ADDR_LSB +: IDX_W];
   always_ff @(posedge axi_clk_pcie)
      if (sys_reset) begin
         r_rdata <= '0;
         r_rresp <= 2'b00;
         r_rlast <= 1'b0;
         r_rerr  <= 1'b0;
      end else if (w_rload) begin
         r_raddr  <= w_roff;
         r_rcnt   <= w_rcnt_n;
         r_rlen   <= w_rlen;
         r_rburst <= w_ridle ? arburst : r_rburst;
         r_rerr   <= w_rerr_n;
         r_rdata  <= (w_rerr_n || !w_rrange) ? '0 : (w_ridx == '0 ? ID_VALUE : r_mem[w_ridx]);
         r_rresp  <= (w_rerr_n || !w_rrange) ? 2'b10 : 2'b00;
         r_rlast  <= w_rcnt_n == w_rlen;
      end
   assign rdata = r_rdata;
   assign rresp = r_rresp;
   assign rlast = r_rlast;
endmodule

// File: tb/tb_axi_bar_regfile_slave.sv
// tb_axi_bar_regfile_slave: table-driven directed bench for the BAR register file responder.
module tb_axi_bar_regfile_slave;
   localparam logic [127:0] ID = 128'hAC0E_0002;
   logic clk = 1'b0, sys_reset;
   logic [31:0] awaddr, araddr;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;
   logic [127:0] wdata, rdata;
   logic [15:0] wstrb;
   int checks = 0, fails = 0, nb;
   logic [127:0] rd_d [16];
   logic [1:0] rd_r [16];
   logic rd_l [16];
   logic [1:0] resp;
   typedef struct {
      bit wr; logic [31:0] a; logic [7:0] len; logic [1:0] bu; logic [2:0] sz;
      logic [7:0] d; logic [15:0] st; logic [1:0] resp; logic [127:0] rd0;
   } vec_t;
   localparam int NV = 22;
   vec_t v [NV];

   axi_bar_regfile_slave dut (
      .axi_clk_pcie(clk), .sys_reset(sys_reset),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awprot(3'd0), .awlock(1'b0), .awcache(4'd0), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arprot(3'd0), .arlock(1'b0), .arcache(4'd0), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] rep(input logic [7:0] b);
      return {16{b}};
   endfunction

   function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [7:0] len,
                               input logic [1:0] bu, input logic [2:0] sz, input logic [7:0] d,
                               input logic [15:0] st, input logic [1:0] rs, input logic [127:0] rd0);
      vec_t x;
      x.wr = wr; x.a = a; x.len = len; x.bu = bu; x.sz = sz; x.d = d; x.st = st; x.resp = rs; x.rd0 = rd0;
      return x;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask

   task automatic wait_on(input string n, ref logic sig);
      int t = 0;
      while (!sig && t < 50) begin step; t++; end
      if (t >= 50) chk({n, "_timeout"}, 128'd0, 128'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                           input logic [2:0] sz, input logic [7:0] d, input logic [15:0] st,
                           input bit badlast, output logic [1:0] rs);
      logic [7:0] db;
      awaddr = a; awlen = len; awburst = bu; awsize = sz; awvalid = 1'b1;
      wait_on("awready", awready);
      step;
      awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         db = d + 8'(b);
         wdata = rep(db); wstrb = st; wlast = (b == int'(len)) && !badlast; wvalid = 1'b1;
         wait_on("wready", wready);
         step;
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      wait_on("bvalid", bvalid);
      rs = bresp;
      step;
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [2:0] sz, input bit tog);
      int t;
      bit stall;
      logic [127:0] hd;
      araddr = a; arlen = len; arburst = bu; arsize = sz; arvalid = 1'b1;
      wait_on("arready", arready);
      step;
      arvalid = 1'b0; nb = 0; stall = 1'b0; t = 0;
      rready = !tog;
      while (nb <= int'(len) && nb < 16 && t < 300) begin
         if (stall) chk("r_hold", rdata, hd);
         stall = rvalid && !rready;
         hd = rdata;
         if (rvalid && rready) begin
            rd_d[nb] = rdata; rd_r[nb] = rresp; rd_l[nb] = rlast; nb++;
         end
         step;
         t++;
         if (tog) rready = !rready;
      end
      rready = 1'b0;
      chk("r_beats", 128'(nb), 128'(int'(len) + 1));
   endtask

   initial begin
      sys_reset = 1'b1;
      awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
      v[0]  = mk(1, 'h10, 0, 1, 4, 'h5A, 'hFFFF, 0, 0);
      v[1]  = mk(0, 'h10, 0, 1, 4, 0, 0, 0, rep(8'h5A));
      v[2]  = mk(1, 'h10, 0, 1, 4, 'hFF, 'h0001, 0, 0);
      v[3]  = mk(0, 'h10, 0, 1, 4, 0, 0, 0, {{15{8'h5A}}, 8'hFF});
      v[4]  = mk(0, 'h0, 0, 1, 4, 0, 0, 0, ID);
      v[5]  = mk(1, 'h0, 0, 1, 4, 'h11, 'hFFFF, 0, 0);
      v[6]  = mk(0, 'h0, 0, 1, 4, 0, 0, 0, ID);
      v[7]  = mk(1, 'h3F0, 1, 1, 4, 'hC0, 'hFFFF, 2, 0);
      v[8]  = mk(0, 'h3F0, 0, 1, 4, 0, 0, 0, rep(8'hC0));
      v[9]  = mk(1, 'h100, 0, 1, 4, 'hA1, 'hFFFF, 0, 0);
      v[10] = mk(1, 'h200, 0, 1, 4, 'hA2, 'hFFFF, 0, 0);
      v[11] = mk(1, 'h100, 0, 1, 3, 'h77, 'hFFFF, 2, 0);
      v[12] = mk(1, 'h200, 0, 2, 4, 'h77, 'hFFFF, 2, 0);
      v[13] = mk(0, 'h100, 0, 1, 4, 0, 0, 0, rep(8'hA1));
      v[14] = mk(0, 'h200, 0, 1, 4, 0, 0, 0, rep(8'hA2));
      v[15] = mk(0, 'h100, 0, 1, 3, 0, 0, 2, 0);
      v[16] = mk(0, 'h200, 2, 2, 4, 0, 0, 2, 0);
      v[17] = mk(0, 'h400, 0, 1, 4, 0, 0, 2, 0);
      v[18] = mk(1, 'h400, 0, 1, 4, 'h66, 'hFFFF, 2, 0);
      v[19] = mk(0, 'h10010, 0, 1, 4, 0, 0, 0, {{15{8'h5A}}, 8'hFF});
      v[20] = mk(1, 'h13, 0, 1, 4, 'h12, 'hFFFF, 0, 0);
      v[21] = mk(0, 'h1F, 0, 1, 4, 0, 0, 0, rep(8'h12));
      repeat (3) step;
      chk("rst_awready", 128'(awready), 1); chk("rst_arready", 128'(arready), 1);
      chk("rst_wready", 128'(wready), 0);   chk("rst_bvalid", 128'(bvalid), 0);
      chk("rst_rvalid", 128'(rvalid), 0);   chk("rst_rlast", 128'(rlast), 0);
      chk("rst_bresp", 128'(bresp), 0);     chk("rst_rresp", 128'(rresp), 0);
      chk("rst_rdata", rdata, 0);
      sys_reset = 1'b0;
      step;
      for (int i = 0; i < NV; i++)
         if (v[i].wr) begin
            do_write(v[i].a, v[i].len, v[i].bu, v[i].sz, v[i].d, v[i].st, 1'b0, resp);
            chk($sformatf("v%0d_bresp", i), 128'(resp), 128'(v[i].resp));
         end else begin
            do_read(v[i].a, v[i].len, v[i].bu, v[i].sz, 1'b0);
            chk($sformatf("v%0d_rdata", i), rd_d[0], v[i].rd0);
            for (int b = 0; b < nb; b++) begin
               chk($sformatf("v%0d_rresp%0d", i, b), 128'(rd_r[b]), 128'(v[i].resp));
               chk($sformatf("v%0d_rlast%0d", i, b), 128'(rd_l[b]), 128'(b == int'(v[i].len)));
            end
         end
      // INCR read running off the end of the file
      do_read('h3F0, 1, 1, 4, 1'b0);
      chk("end_d0", rd_d[0], rep(8'hC0)); chk("end_r0", 128'(rd_r[0]), 0); chk("end_l0", 128'(rd_l[0]), 0);
      chk("end_d1", rd_d[1], 0);          chk("end_r1", 128'(rd_r[1]), 2); chk("end_l1", 128'(rd_l[1]), 1);
      // partial-strobe INCR burst over previously filled words
      do_write('h20, 3, 1, 4, 'hB0, 'hFFFF, 1'b0, resp);
      chk("fill_bresp", 128'(resp), 0);
      do_write('h20, 3, 1, 4, 'hE0, 'h00FF, 1'b0, resp);
      chk("strb_bresp", 128'(resp), 0);
      do_read('h20, 3, 1, 4, 1'b0);
      for (int b = 0; b < nb; b++) begin
         chk($sformatf("strb_d%0d", b), rd_d[b], {{8{8'hB0 + 8'(b)}}, {8{8'hE0 + 8'(b)}}});
         chk($sformatf("strb_l%0d", b), 128'(rd_l[b]), 128'(b == 3));
      end
      // FIXED burst: every beat lands on the same word
      do_write('h60, 2, 0, 4, 'h30, 'hFFFF, 1'b0, resp);
      chk("fixed_bresp", 128'(resp), 0);
      do_read('h60, 2, 0, 4, 1'b0);
      for (int b = 0; b < nb; b++) chk($sformatf("fixed_d%0d", b), rd_d[b], rep(8'h32));
      // wlast missing on the counted last beat
      do_write('h70, 1, 1, 4, 'h50, 'hFFFF, 1'b1, resp);
      chk("wlast_bresp", 128'(resp), 2);
      // back-pressured len7 read
      do_write('h80, 7, 1, 4, 'h40, 'hFFFF, 1'b0, resp);
      chk("w8_bresp", 128'(resp), 0);
      do_read('h80, 7, 1, 4, 1'b1);
      for (int b = 0; b < nb; b++) begin
         chk($sformatf("tog_d%0d", b), rd_d[b], rep(8'h40 + 8'(b)));
         chk($sformatf("tog_l%0d", b), 128'(rd_l[b]), 128'(b == 7));
      end
      // reset in the middle of a read burst
      araddr = 'h80; arlen = 7; arburst = 1; arsize = 4; arvalid = 1'b1;
      step;
      arvalid = 1'b0; rready = 1'b1;
      step; step;
      sys_reset = 1'b1;
      step;
      sys_reset = 1'b0; rready = 1'b0;
      chk("rrst_rvalid", 128'(rvalid), 0); chk("rrst_arready", 128'(arready), 1);
      chk("rrst_rlast", 128'(rlast), 0);
      // reset in the middle of a write burst: first beat stays written
      awaddr = 'h80; awlen = 3; awburst = 1; awsize = 4; awvalid = 1'b1;
      step;
      awvalid = 1'b0; wdata = rep(8'h99); wstrb = 'hFFFF; wvalid = 1'b1;
      step;
      wvalid = 1'b0; sys_reset = 1'b1;
      step;
      sys_reset = 1'b0;
      chk("wrst_wready", 128'(wready), 0); chk("wrst_bvalid", 128'(bvalid), 0);
      chk("wrst_awready", 128'(awready), 1);
      do_read('h80, 1, 1, 4, 1'b0);
      chk("wrst_d0", rd_d[0], rep(8'h99)); chk("wrst_d1", rd_d[1], rep(8'h41));
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
